// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with writable synaptic weights.
// Optional refractory period enabled by LIF_NEURON_REFRACTORY_EN.
module lif_neuron #(
  parameter int NUM_IN        = 4,
  parameter int W_WIDTH       = 4,
  parameter int V_WIDTH       = 8,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRAC_CYCLES = 3,
  parameter int WEIGHT_INIT   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_IN-1:0]         spike_in,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_IN)-1:0] wr_addr,
  input  logic [W_WIDTH-1:0]        wr_data,
  input  logic [V_WIDTH-1:0]        threshold,
  output logic                      fire_out,
  output logic [V_WIDTH-1:0]        v_mem,
  output logic                      refrac_busy
);

  localparam int SW = W_WIDTH + $clog2(NUM_IN + 1);
  localparam int AW = ((SW > V_WIDTH) ? SW : V_WIDTH) + 1;
  localparam logic [V_WIDTH-1:0] VMAX = '1;
  localparam logic [W_WIDTH-1:0] WINIT = W_WIDTH'(WEIGHT_INIT);

  logic [W_WIDTH-1:0] weight [NUM_IN];
  logic [AW-1:0]      syn_sum;
  logic [AW-1:0]      acc;
  logic [V_WIDTH-1:0] v_next;
  logic               fire_next;

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (spike_in[i]) syn_sum = syn_sum + AW'(weight[i]);
    end
  end

  always_comb begin
    acc = AW'(v_mem) + syn_sum;
    if (|spike_in) begin
      v_next = (acc > AW'(VMAX)) ? VMAX : acc[V_WIDTH-1:0];
    end else begin
      v_next = v_mem >> LEAK_SHIFT;
    end
    fire_next = (threshold != '0) && (v_next >= threshold);
  end

  // Integration above reads the old weight, so a same-edge write is not seen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) weight[i] <= WINIT;
    end else if (wr_en && (int'(wr_addr) < NUM_IN)) begin
      weight[wr_addr] <= wr_data;
    end
  end

`ifdef LIF_NEURON_REFRACTORY_EN
  localparam int CW = $clog2(REFRAC_CYCLES + 1);

  logic [CW-1:0] refrac_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refrac_cnt <= '0;
      fire_out   <= 1'b0;
      v_mem      <= '0;
    end else if (refrac_cnt != '0) begin
      refrac_cnt <= refrac_cnt - CW'(1);
      fire_out   <= 1'b0;
      v_mem      <= '0;
    end else if (fire_next) begin
      refrac_cnt <= CW'(REFRAC_CYCLES);
      fire_out   <= 1'b1;
      v_mem      <= '0;
    end else begin
      fire_out   <= 1'b0;
      v_mem      <= v_next;
    end
  end

  assign refrac_busy = (refrac_cnt != '0);
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fire_out <= 1'b0;
      v_mem    <= '0;
    end else begin
      fire_out <= fire_next;
      v_mem    <= fire_next ? '0 : v_next;
    end
  end

  assign refrac_busy = 1'b0;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron: directed vectors, expected
// outputs queued by the driver and checked by a separate monitor.
module tb_lif_neuron;

  logic       clk;
  logic       reset_n;
  logic [3:0] spike_in;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] threshold;
  logic       fire_out;
  logic [7:0] v_mem;
  logic       refrac_busy;

  int n_tests;
  int n_fail;

  typedef struct {
    string      name;
    logic       f;
    logic [7:0] v;
    logic       b;
  } exp_t;

  exp_t exp_q[$];

  lif_neuron dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spike_in   (spike_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .threshold  (threshold),
    .fire_out   (fire_out),
    .v_mem      (v_mem),
    .refrac_busy(refrac_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic ef,
                     input logic [7:0] ev, input logic eb);
    n_tests++;
    if (fire_out !== ef || v_mem !== ev || refrac_busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got fire=%b v=%0d busy=%b, want fire=%b v=%0d busy=%b",
               name, fire_out, v_mem, refrac_busy, ef, ev, eb);
    end
  endtask

  // Monitor: one expected entry per clock edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, e.f, e.v, e.b);
    end
  end

  task automatic step(input string name, input logic [3:0] sp,
                      input logic we, input logic [1:0] wa,
                      input logic [3:0] wd, input logic [7:0] th,
                      input logic [7:0] ev, input logic ef,
                      input logic eb);
    exp_t e;
    @(negedge clk);
    spike_in  = sp;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    threshold = th;
    e.name = name;
    e.f = ef;
    e.v = ev;
    e.b = eb;
    exp_q.push_back(e);
  endtask

  task automatic run(input string name, input logic [3:0] sp,
                     input logic [7:0] th, input logic [7:0] ev,
                     input logic ef);
    step(name, sp, 1'b0, 2'd0, 4'd0, th, ev, ef, 1'b0);
  endtask

  task automatic wr(input string name, input logic [1:0] wa,
                    input logic [3:0] wd, input logic [3:0] sp,
                    input logic [7:0] ev);
    step(name, sp, 1'b1, wa, wd, 8'd0, ev, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] sat_seq [6];
    logic [7:0] leak_seq [6];
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    spike_in  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    threshold = '0;
    sat_seq   = '{8'd60, 8'd120, 8'd180, 8'd240, 8'd255, 8'd255};
    leak_seq  = '{8'd8, 8'd4, 8'd2, 8'd1, 8'd0, 8'd0};

    repeat (2) @(negedge clk);
    cmp("reset_state", 1'b0, 8'd0, 1'b0);
    reset_n = 1'b1;

    // threshold 3, unit weights
    run("thr3_e1", 4'b0001, 8'd3, 8'd1, 1'b0);
    run("thr3_e2", 4'b0001, 8'd3, 8'd2, 1'b0);
    run("thr3_fire", 4'b0001, 8'd3, 8'd0, 1'b1);
    run("thr3_after", 4'b0000, 8'd0, 8'd0, 1'b0);

    // same-edge write uses the old weight
    wr("wr_spike_old", 2'd0, 4'd5, 4'b0001, 8'd1);
    run("wr_spike_new", 4'b0001, 8'd0, 8'd6, 1'b0);
    run("leak_6", 4'b0000, 8'd0, 8'd3, 1'b0);
    run("leak_3", 4'b0000, 8'd0, 8'd1, 1'b0);
    run("leak_1", 4'b0000, 8'd0, 8'd0, 1'b0);

    // leak chain from 8
    wr("wr_w0_8", 2'd0, 4'd8, 4'b0000, 8'd0);
    for (int i = 0; i < 6; i++)
      run($sformatf("leak_seq%0d", i), (i == 0) ? 4'b0001 : 4'b0000,
          8'd0, leak_seq[i], 1'b0);

    // saturation with all weights 15
    for (int i = 0; i < 4; i++)
      wr($sformatf("wr_w%0d_15", i), 2'(i), 4'd15, 4'b0000, 8'd0);
    for (int i = 0; i < 6; i++)
      run($sformatf("sat%0d", i), 4'b1111, 8'd0, sat_seq[i], 1'b0);

    // threshold equal to saturated potential fires
    run("thr_eq_max", 4'b1111, 8'd255, 8'd0, 1'b1);
    run("thr_idle", 4'b0000, 8'd0, 8'd0, 1'b0);

    // continuous drive at threshold 1
`ifdef LIF_NEURON_REFRACTORY_EN
    step("ref_fire1", 4'b0001, 1'b0, 2'd0, 4'd0, 8'd1, 8'd0, 1'b1, 1'b1);
    step("ref_hold1", 4'b0001, 1'b0, 2'd0, 4'd0, 8'd1, 8'd0, 1'b0, 1'b1);
    step("ref_hold2", 4'b0001, 1'b0, 2'd0, 4'd0, 8'd1, 8'd0, 1'b0, 1'b1);
    step("ref_hold3", 4'b0001, 1'b0, 2'd0, 4'd0, 8'd1, 8'd0, 1'b0, 1'b0);
    step("ref_fire2", 4'b0001, 1'b0, 2'd0, 4'd0, 8'd1, 8'd0, 1'b1, 1'b1);
    step("ref_idle1", 4'b0000, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    step("ref_idle2", 4'b0000, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    step("ref_idle3", 4'b0000, 1'b0, 2'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 5; i++)
      run($sformatf("fire_each%0d", i), 4'b0001, 8'd1, 8'd0, 1'b1);
    run("fire_stop", 4'b0000, 8'd0, 8'd0, 1'b0);
`endif

    // build v_mem = 100 then reset asynchronously between edges
    wr("wr_w1_10", 2'd1, 4'd10, 4'b0000, 8'd0);
    run("build25", 4'b0011, 8'd0, 8'd25, 1'b0);
    run("build50", 4'b0011, 8'd0, 8'd50, 1'b0);
    run("build75", 4'b0011, 8'd0, 8'd75, 1'b0);
    run("build100", 4'b0011, 8'd0, 8'd100, 1'b0);
    @(negedge clk);
    spike_in = '0;
    #1 reset_n = 1'b0;
    #1 cmp("async_reset", 1'b0, 8'd0, 1'b0);
    #1 reset_n = 1'b1;
    run("post_rst_w0", 4'b0001, 8'd0, 8'd1, 1'b0);
    run("post_rst_all", 4'b1111, 8'd0, 8'd5, 1'b0);

    repeat (2) @(negedge clk);
    spike_in = '0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
